// File: rtl/qspi_ram_responder_pkg.sv
// Shared definitions for the QSPI RAM responder: QPI opcodes, decoder
// states and the busy-state classification.
package qspi_ram_responder_pkg;

    localparam logic [7:0] QPI_READ     = 8'hEB;
    localparam logic [7:0] QPI_WRITE    = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // A transaction addressed to this bank is being decoded or served.
    function automatic logic state_is_busy(input state_t s);
        logic busy_v;
        case (s)
            ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA: busy_v = 1'b1;
            default:                                       busy_v = 1'b0;
        endcase
        return busy_v;
    endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Brings the asynchronous RAM pins into the system clock domain through two
// flops each and derives one-cycle edge strobes for ram_clk and csn.
module qspi_pin_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic       ram_clk,
    input  logic       ram_csn,
    input  logic [1:0] ram_bank,
    input  logic [3:0] ram_io,
    output logic       csn_s,
    output logic [1:0] bank_s,
    output logic [3:0] io_s,
    output logic       rise_s,
    output logic       fall_s,
    output logic       csn_rise_s
);

    logic       clk_meta_r;
    logic       clk_sync_r;
    logic       clk_prev_r;
    logic       csn_meta_r;
    logic       csn_sync_r;
    logic       csn_prev_r;
    logic [1:0] bank_meta_r;
    logic [1:0] bank_sync_r;
    logic [3:0] io_meta_r;
    logic [3:0] io_sync_r;

    // Two-flop synchronisers plus one history flop for edge detection; csn idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_r  <= 1'b0;
            clk_sync_r  <= 1'b0;
            clk_prev_r  <= 1'b0;
            csn_meta_r  <= 1'b1;
            csn_sync_r  <= 1'b1;
            csn_prev_r  <= 1'b1;
            bank_meta_r <= 2'd0;
            bank_sync_r <= 2'd0;
            io_meta_r   <= 4'd0;
            io_sync_r   <= 4'd0;
        end else begin
            clk_meta_r  <= ram_clk;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            csn_meta_r  <= ram_csn;
            csn_sync_r  <= csn_meta_r;
            csn_prev_r  <= csn_sync_r;
            bank_meta_r <= ram_bank;
            bank_sync_r <= bank_meta_r;
            io_meta_r   <= ram_io;
            io_sync_r   <= io_meta_r;
        end
    end

    assign csn_s      = csn_sync_r;
    assign bank_s     = bank_sync_r;
    assign io_s       = io_sync_r;
    assign rise_s     = clk_sync_r & ~clk_prev_r;
    assign fall_s     = ~clk_sync_r & clk_prev_r;
    assign csn_rise_s = csn_sync_r & ~csn_prev_r;

endmodule

// File: rtl/qspi_ram_responder.sv
// Device side of the QSPI RAM PMOD link: decodes QPI quad read (0xEB) and
// quad write (0x38) and serves them from an on-chip byte-wide BRAM.
// ADDR_W must lie in 5..24 (address nibbles are shifted into the low bits).
module qspi_ram_responder
    import qspi_ram_responder_pkg::*;
#(
    parameter int         ADDR_W  = 10,
    parameter int         DUMMY   = 6,
    parameter logic [1:0] BANK_ID = 2'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_ram_clk,
    input  logic       in_ram_csn,
    input  logic [1:0] in_ram_bank,
    input  logic [3:0] in_ram_io_i,
    output logic [3:0] out_ram_io_o,
    output logic       out_ram_io_oe,
    output logic       out_busy,
    output logic       out_cmd_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DUMMY + ADDR_NIBBLES + 1);

    logic              csn_s, rise_s, fall_s, csn_rise_s;
    logic [1:0]        bank_s;
    logic [3:0]        io_s;

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [3:0]        cmd_hi_r, cmd_hi_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [3:0]        wnib_r, wnib_n;
    logic              wph_r, wph_n;
    logic              hi_next_r, hi_next_n;
    logic              is_read_r, is_read_n;
    logic [3:0]        io_o_r, io_o_n;
    logic              oe_r, oe_n;
    logic              busy_r;
    logic              err_r, err_n;
    logic              we_s;
    logic [7:0]        opcode_s;
    logic [7:0]        wdata_s;
    logic [7:0]        rdata_r;
    logic [7:0]        mem_r [0:DEPTH-1];

    qspi_pin_sync u_sync (
        .clock      (clock),
        .reset      (reset),
        .ram_clk    (in_ram_clk),
        .ram_csn    (in_ram_csn),
        .ram_bank   (in_ram_bank),
        .ram_io     (in_ram_io_i),
        .csn_s      (csn_s),
        .bank_s     (bank_s),
        .io_s       (io_s),
        .rise_s     (rise_s),
        .fall_s     (fall_s),
        .csn_rise_s (csn_rise_s)
    );

    assign opcode_s = {cmd_hi_r, io_s};
    assign wdata_s  = {wnib_r, io_s};

    // Next-state and datapath decode; csn release overrides any clock edge.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        cmd_hi_n  = cmd_hi_r;
        addr_n    = addr_r;
        wnib_n    = wnib_r;
        wph_n     = wph_r;
        hi_next_n = hi_next_r;
        is_read_n = is_read_r;
        io_o_n    = io_o_r;
        oe_n      = oe_r;
        err_n     = 1'b0;
        we_s      = 1'b0;
        if ((state_r != ST_IDLE) && csn_rise_s) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            wph_n   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    oe_n  = 1'b0;
                    cnt_n = {CNT_W{1'b0}};
                    if (!csn_s) begin
                        state_n = (bank_s == BANK_ID) ? ST_CMD : ST_IGNORE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (rise_s && (cnt_r == CNT_W'(1'b0))) begin
                        cmd_hi_n = io_s;
                        cnt_n    = CNT_W'(1'b1);
                    end else if (rise_s) begin
                        cnt_n = {CNT_W{1'b0}};
                        if ((opcode_s == QPI_READ) || (opcode_s == QPI_WRITE)) begin
                            state_n   = ST_ADDR;
                            is_read_n = (opcode_s == QPI_READ);
                        end else begin
                            state_n = ST_IGNORE;
                            err_n   = 1'b1;
                        end
                    end else begin
                        state_n = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (rise_s) begin
                        addr_n = {addr_r[ADDR_W-5:0], io_s};
                        if (cnt_r == CNT_W'(ADDR_NIBBLES - 1)) begin
                            cnt_n   = {CNT_W{1'b0}};
                            wph_n   = 1'b0;
                            state_n = is_read_r ? ST_DUMMY : ST_WDATA;
                        end else begin
                            cnt_n = cnt_r + CNT_W'(1'b1);
                        end
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                ST_DUMMY: begin
                    if (rise_s && (cnt_r != CNT_W'(DUMMY))) begin
                        cnt_n = cnt_r + CNT_W'(1'b1);
                    end else if (fall_s && (cnt_r == CNT_W'(DUMMY))) begin
                        state_n   = ST_RDATA;
                        oe_n      = 1'b1;
                        io_o_n    = rdata_r[7:4];
                        hi_next_n = 1'b0;
                    end else begin
                        state_n = ST_DUMMY;
                    end
                end
                ST_RDATA: begin
                    if (fall_s && hi_next_r) begin
                        io_o_n    = rdata_r[7:4];
                        hi_next_n = 1'b0;
                    end else if (fall_s) begin
                        io_o_n    = rdata_r[3:0];
                        hi_next_n = 1'b1;
                        addr_n    = addr_r + ADDR_W'(1'b1);
                    end else begin
                        state_n = ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (rise_s && !wph_r) begin
                        wnib_n = io_s;
                        wph_n  = 1'b1;
                    end else if (rise_s) begin
                        we_s   = 1'b1;
                        wph_n  = 1'b0;
                        addr_n = addr_r + ADDR_W'(1'b1);
                    end else begin
                        state_n = ST_WDATA;
                    end
                end
                ST_IGNORE: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered pin outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            cmd_hi_r  <= 4'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wnib_r    <= 4'd0;
            wph_r     <= 1'b0;
            hi_next_r <= 1'b0;
            is_read_r <= 1'b0;
            io_o_r    <= 4'd0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            cmd_hi_r  <= cmd_hi_n;
            addr_r    <= addr_n;
            wnib_r    <= wnib_n;
            wph_r     <= wph_n;
            hi_next_r <= hi_next_n;
            is_read_r <= is_read_n;
            io_o_r    <= io_o_n;
            oe_r      <= oe_n;
            busy_r    <= state_is_busy(state_n);
            err_r     <= err_n;
        end
    end

    // Byte-wide BRAM with registered read of the current burst address; contents survive reset.
    always_ff @(posedge clock) begin
        if (we_s && !reset) begin
            mem_r[addr_r] <= wdata_s;
        end
        rdata_r <= mem_r[addr_r];
    end

    assign out_ram_io_o  = io_o_r;
    assign out_ram_io_oe = oe_r;
    assign out_busy      = busy_r;
    assign out_cmd_err   = err_r;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Self-checking bench for qspi_ram_responder: acts as the RAM controller,
// drives QPI transactions bit-banged on ram_clk and compares read data
// against a byte-array model of the memory.
module tb_qspi_ram_responder;
    import qspi_ram_responder_pkg::*;

    localparam int HALF   = 6;
    localparam int DEPTH  = 1024;
    localparam int NDUMMY = 6;

    logic       clock;
    logic       reset;
    logic       in_ram_clk;
    logic       in_ram_csn;
    logic [1:0] in_ram_bank;
    logic [3:0] in_ram_io_i;
    logic [3:0] out_ram_io_o;
    logic       out_ram_io_oe;
    logic       out_busy;
    logic       out_cmd_err;

    int n_chk = 0;
    int n_fail = 0;
    int err_cycles = 0;
    int oe_cycles = 0;

    logic [7:0] ref_mem [0:DEPTH-1];
    logic [7:0] wbuf [0:3];
    logic [7:0] rbuf [0:3];
    logic       rd_oe_ok;
    logic       dummy_oe_seen;

    typedef struct packed {
        logic [7:0]  op;
        logic [1:0]  bank;
        logic [31:0] exp_err;
        logic        exp_busy;
    } vec_t;
    vec_t vecs [0:5];

    qspi_ram_responder #(.ADDR_W(10), .DUMMY(NDUMMY), .BANK_ID(2'd0)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_ram_clk    (in_ram_clk),
        .in_ram_csn    (in_ram_csn),
        .in_ram_bank   (in_ram_bank),
        .in_ram_io_i   (in_ram_io_i),
        .out_ram_io_o  (out_ram_io_o),
        .out_ram_io_oe (out_ram_io_oe),
        .out_busy      (out_busy),
        .out_cmd_err   (out_cmd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (out_cmd_err) err_cycles <= err_cycles + 1;
        if (out_ram_io_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cs_low(input logic [1:0] b);
        in_ram_bank = b;
        in_ram_csn  = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        in_ram_clk = 1'b0;
        in_ram_csn = 1'b1;
        tick(HALF);
    endtask

    task automatic send_nib(input logic [3:0] n);
        in_ram_io_i = n;
        tick(HALF);
        in_ram_clk = 1'b1;
        tick(HALF);
        in_ram_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic pulse();
        tick(HALF);
        if (out_ram_io_oe) dummy_oe_seen = 1'b1;
        in_ram_clk = 1'b1;
        tick(HALF);
        if (out_ram_io_oe) dummy_oe_seen = 1'b1;
        in_ram_clk = 1'b0;
    endtask

    task automatic recv_nib(output logic [3:0] nib, output logic oe);
        tick(HALF);
        nib = out_ram_io_o;
        oe  = out_ram_io_oe;
        in_ram_clk = 1'b1;
        tick(HALF);
        in_ram_clk = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        cs_low(2'd0);
        send_byte(QPI_WRITE);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i]);
            ref_mem[(int'(a[9:0]) + i) % DEPTH] = wbuf[i];
        end
        cs_high();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [3:0] h, l;
        logic       oh, ol;
        cs_low(2'd0);
        send_byte(QPI_READ);
        send_addr(a);
        dummy_oe_seen = 1'b0;
        repeat (NDUMMY) pulse();
        rd_oe_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            recv_nib(h, oh);
            recv_nib(l, ol);
            rbuf[i] = {h, l};
            if (!oh || !ol) rd_oe_ok = 1'b0;
        end
        cs_high();
    endtask

    initial begin
        logic [3:0]  nib;
        logic        noe;
        logic [23:0] a, a2;
        int          n, e0, o0;

        vecs[0] = '{8'hEB, 2'd0, 32'd0, 1'b1};
        vecs[1] = '{8'h38, 2'd0, 32'd0, 1'b1};
        vecs[2] = '{8'h9F, 2'd0, 32'd1, 1'b0};
        vecs[3] = '{8'h00, 2'd0, 32'd1, 1'b0};
        vecs[4] = '{8'hEB, 2'd2, 32'd0, 1'b0};
        vecs[5] = '{8'h38, 2'd1, 32'd0, 1'b0};

        reset = 1'b1;
        in_ram_clk = 1'b0;
        in_ram_csn = 1'b1;
        in_ram_bank = 2'd0;
        in_ram_io_i = 4'd0;
        tick(5);
        chk("reset_io_o", 32'(out_ram_io_o), 32'd0);
        chk("reset_oe", 32'(out_ram_io_oe), 32'd0);
        chk("reset_busy", 32'(out_busy), 32'd0);
        chk("reset_cmd_err", 32'(out_cmd_err), 32'd0);
        reset = 1'b0;
        tick(3);

        // Write A5 3C at 0x10, read back with nibble-level checks.
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h3C;
        do_write(24'h000010, 2);
        do_read(24'h000010, 2);
        chk("rd_nib0", 32'(rbuf[0][7:4]), 32'hA);
        chk("rd_nib1", 32'(rbuf[0][3:0]), 32'h5);
        chk("rd_nib2", 32'(rbuf[1][7:4]), 32'h3);
        chk("rd_nib3", 32'(rbuf[1][3:0]), 32'hC);
        chk("rd_oe_low_in_dummy", 32'(dummy_oe_seen), 32'd0);
        chk("rd_oe_high_in_data", 32'(rd_oe_ok), 32'd1);
        chk("rd_oe_after_csn", 32'(out_ram_io_oe), 32'd0);

        // Burst wrap from the top of memory to address 0.
        wbuf[0] = 8'h11;
        do_write(24'h0003FF, 1);
        wbuf[0] = 8'h22;
        do_write(24'h000000, 1);
        do_read(24'h0003FF, 2);
        chk("wrap_byte0", 32'(rbuf[0]), 32'h11);
        chk("wrap_byte1", 32'(rbuf[1]), 32'h22);

        // Opcode / bank table: busy after opcode and after a follow-on byte, error pulse width, oe.
        for (int v = 0; v < 6; v++) begin
            e0 = err_cycles;
            o0 = oe_cycles;
            cs_low(vecs[v].bank);
            send_byte(vecs[v].op);
            tick(1);
            chk($sformatf("tbl%0d_busy_op", v), 32'(out_busy), 32'(vecs[v].exp_busy));
            send_byte(8'hEB);
            chk($sformatf("tbl%0d_busy_next", v), 32'(out_busy), 32'(vecs[v].exp_busy));
            cs_high();
            chk($sformatf("tbl%0d_busy_end", v), 32'(out_busy), 32'd0);
            chk($sformatf("tbl%0d_err_cycles", v), 32'(err_cycles - e0), vecs[v].exp_err);
            chk($sformatf("tbl%0d_oe_cycles", v), 32'(oe_cycles - o0), 32'd0);
        end

        // Write attempt on a foreign bank must not touch memory.
        o0 = oe_cycles;
        cs_low(2'd2);
        send_byte(QPI_WRITE);
        send_addr(24'h000010);
        send_byte(8'hFF);
        send_byte(8'hFF);
        cs_high();
        chk("bank_oe_cycles", 32'(oe_cycles - o0), 32'd0);
        do_read(24'h000010, 2);
        chk("bank_mem0", 32'(rbuf[0]), 32'hA5);
        chk("bank_mem1", 32'(rbuf[1]), 32'h3C);

        // Write aborted after three nibbles: first byte lands, second does not.
        wbuf[0] = 8'h99;
        do_write(24'h000021, 1);
        cs_low(2'd0);
        send_byte(QPI_WRITE);
        send_addr(24'h000020);
        send_byte(8'h5A);
        send_nib(4'h7);
        cs_high();
        ref_mem[32] = 8'h5A;
        chk("partial_oe", 32'(out_ram_io_oe), 32'd0);
        chk("partial_busy", 32'(out_busy), 32'd0);
        do_read(24'h000020, 2);
        chk("partial_byte20", 32'(rbuf[0]), 32'h5A);
        chk("partial_byte21", 32'(rbuf[1]), 32'h99);

        // Reset in the middle of a read burst.
        cs_low(2'd0);
        send_byte(QPI_READ);
        send_addr(24'h000010);
        repeat (NDUMMY) pulse();
        recv_nib(nib, noe);
        chk("rst_pre_nib", 32'(nib), 32'hA);
        chk("rst_pre_oe", 32'(noe), 32'd1);
        tick(HALF);
        chk("rst_pre_busy", 32'(out_busy), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("rst_oe", 32'(out_ram_io_oe), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        reset = 1'b0;
        in_ram_csn = 1'b1;
        tick(HALF);
        do_read(24'h000010, 2);
        chk("rst_after_byte0", 32'(rbuf[0]), 32'hA5);
        chk("rst_after_byte1", 32'(rbuf[1]), 32'h3C);

        // Random bursts against the byte-array model; read uses different upper address bits.
        for (int t = 0; t < 12; t++) begin
            a = 24'($urandom);
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n);
            a2 = {14'($urandom), a[9:0]};
            do_read(a2, n);
            for (int i = 0; i < n; i++) begin
                chk($sformatf("rnd%0d_byte%0d", t, i), 32'(rbuf[i]),
                    32'(ref_mem[(int'(a[9:0]) + i) % DEPTH]));
            end
            chk($sformatf("rnd%0d_oe", t), 32'(rd_oe_ok), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
